vram_wr_arb: RTL and testbench

- Arbitrates the single framebuffer (vram) write port between N_REQ pixel producers: text renderer, CPU pixel path, future sprite/blit engines.
- Contains a built-in clear sequencer that fills the whole 280x192 framebuffer with one colour, one word per cycle.
- Sits between the producers and the vram write-side pins (w_adr, d, we); the vga scan-out read side is untouched.

---
 rtl/vdp_pkg.sv | 23 ++
 rtl/vram_wr_arb_rr_arbiter.sv | 51 +++++
 rtl/vram_wr_arb.sv | 156 +++++++++++++++
 tb/tb_vram_wr_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// -----------------------------------------------------------------------------
// vdp_pkg
// Shared video-pipeline definitions: framebuffer geometry, pixel/address
// types, the vram write-arbiter state encoding and the grant_id value that
// marks writes issued by the clear sequencer.
// -----------------------------------------------------------------------------
package vdp_pkg;

    localparam int FB_W     = 280;
    localparam int FB_H     = 192;
    localparam int FB_WORDS = FB_W * FB_H;

    typedef logic [23:0] pixel_t;
    typedef logic [15:0] vadr_t;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    localparam logic [2:0] GRANT_CLEAR = 3'd7;

endpackage

// File: rtl/vram_wr_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: combinational one-hot grant to the first asserted req
// at or above the pointer (wrapping modulo N); the pointer moves to the slot
// after the winner whenever a grant is issued.
//
// Ports:
//   clk        in   clock (posedge)
//   rst_n      in   asynchronous active-low reset, pointer -> 0
//   req        in   N  request vector (already qualified by the caller)
//   grant      out  N  one-hot grant, zero when nothing requests
//   grant_idx  out  3  binary index of the granted bit (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic [2:0]   grant_idx
);

    logic [2:0] ptr_q;

    always_comb begin
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int off = 0; off < N; off++) begin
            int j;
            j = int'(ptr_q) + off;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = 3'(j);
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (|grant) begin
            ptr_q <= (grant_idx == 3'(N - 1)) ? 3'd0 : grant_idx + 3'd1;
        end
    end

endmodule

// File: rtl/vram_wr_arb.sv
// -----------------------------------------------------------------------------
// vram_wr_arb
// Shares the single framebuffer write port among N_REQ pixel producers with
// round-robin arbitration, and contains a clear sequencer that fills all
// FB_WORDS words with one colour at one word per cycle.
//
// Ports:
//   CLOCK_50     in   system clock
//   reset_n      in   asynchronous active-low reset
//   req_valid    in   N_REQ      per-requester write request
//   req_ready    out  N_REQ      per-requester accept (combinational, one-hot)
//   req_adr      in   N_REQ*AW   packed addresses, requester i at [i*AW +: AW]
//   req_d        in   N_REQ*DW   packed pixel data, same packing
//   clear_start  in   pulse starting a framebuffer clear
//   clear_color  in   DW         fill colour, captured with clear_start
//   clear_busy   out  clear sequence running
//   vram_we      out  registered write enable
//   vram_wadr    out  AW         registered write address
//   vram_d       out  DW         registered write data
//   grant_id     out  3          source of the current write (7 = clear)
//   grant_cnt    out  N_REQ*32   per-requester transfer counters (stats only)
//   clear_cnt    out  16         completed-clear counter (stats only)
//
// Build option: define VRAM_WR_ARB_STATS_EN to add grant_cnt / clear_cnt.
// -----------------------------------------------------------------------------
module vram_wr_arb #(
    parameter int N_REQ    = 3,
    parameter int DW       = 24,
    parameter int AW       = 16,
    parameter int FB_WORDS = vdp_pkg::FB_WORDS
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*AW-1:0] req_adr,
    input  logic [N_REQ*DW-1:0] req_d,
    input  logic                clear_start,
    input  logic [DW-1:0]       clear_color,
    output logic                clear_busy,
    output logic                vram_we,
    output logic [AW-1:0]       vram_wadr,
    output logic [DW-1:0]       vram_d,
`ifdef VRAM_WR_ARB_STATS_EN
    output logic [N_REQ*32-1:0] grant_cnt,
    output logic [15:0]         clear_cnt,
`endif
    output logic [2:0]          grant_id
);

    import vdp_pkg::*;

    localparam logic [AW-1:0] LAST_ADR = AW'(FB_WORDS - 1);

    arb_state_t       state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    color_q, color_d;
    logic             we_d;
    logic [AW-1:0]    wadr_d;
    logic [DW-1:0]    d_d;
    logic [2:0]       gid_d;
    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] grant;
    logic [2:0]       grant_idx;

    // Requests only compete in ARB, outside reset, and never in the cycle a
    // clear is requested; so every grant is a transfer.
    assign arb_req    = (reset_n && state_q == ARB && !clear_start) ? req_valid : '0;
    assign req_ready  = grant;
    assign clear_busy = (state_q == CLEAR);

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .clk       (CLOCK_50),
        .rst_n     (reset_n),
        .req       (arb_req),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        we_d    = 1'b0;
        wadr_d  = vram_wadr;
        d_d     = vram_d;
        gid_d   = grant_id;
        case (state_q)
            ARB: begin
                if (clear_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    color_d = clear_color;
                end else if (|grant) begin
                    we_d   = 1'b1;
                    wadr_d = req_adr[grant_idx*AW +: AW];
                    d_d    = req_d[grant_idx*DW +: DW];
                    gid_d  = grant_idx;
                end
            end
            CLEAR: begin
                we_d   = 1'b1;
                wadr_d = cnt_q;
                d_d    = color_q;
                gid_d  = GRANT_CLEAR;
                if (cnt_q == LAST_ADR) begin
                    state_d = ARB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ARB;
            cnt_q     <= '0;
            vram_we   <= 1'b0;
            vram_wadr <= '0;
            vram_d    <= '0;
            grant_id  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vram_we   <= we_d;
            vram_wadr <= wadr_d;
            vram_d    <= d_d;
            grant_id  <= gid_d;
        end
    end

    // Fill colour is pure data and is always written before use.
    always_ff @(posedge CLOCK_50) begin
        color_q <= color_d;
    end

`ifdef VRAM_WR_ARB_STATS_EN
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            grant_cnt <= '0;
            clear_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i]) grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
            end
            if (state_q == CLEAR && cnt_q == LAST_ADR) clear_cnt <= clear_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_wr_arb.sv
module tb_vram_wr_arb;

    localparam int N_REQ = 3;
    localparam int DW    = 24;
    localparam int AW    = 16;
    localparam int FBW   = 53760;

    logic                CLOCK_50;
    logic                reset_n;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*AW-1:0] req_adr;
    logic [N_REQ*DW-1:0] req_d;
    logic                clear_start;
    logic [DW-1:0]       clear_color;
    logic                clear_busy;
    logic                vram_we;
    logic [AW-1:0]       vram_wadr;
    logic [DW-1:0]       vram_d;
    logic [2:0]          grant_id;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] d;
        logic [2:0]    gid;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fails;

    vram_wr_arb dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_adr     (req_adr),
        .req_d       (req_d),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .vram_we     (vram_we),
        .vram_wadr   (vram_wadr),
        .vram_d      (vram_d),
        .grant_id    (grant_id)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] g);
        exp_t e;
        e.adr = a;
        e.d   = d;
        e.gid = g;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every vram write must match the oldest expectation.
    always @(negedge CLOCK_50) begin
        if (reset_n && vram_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_write: got adr=%0h d=%0h gid=%0d expected no write",
                         vram_wadr, vram_d, grant_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (vram_wadr !== e.adr || vram_d !== e.d || grant_id !== e.gid) begin
                    n_fails++;
                    $display("FAIL write: got adr=%0h d=%0h gid=%0d expected adr=%0h d=%0h gid=%0d",
                             vram_wadr, vram_d, grant_id, e.adr, e.d, e.gid);
                end
            end
        end
    end

    initial begin
        int busy_cycles;
        bit timed_out;
        logic [2:0] exp_gid [6];
        exp_gid = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
        n_checks    = 0;
        n_fails     = 0;
        reset_n     = 1'b0;
        req_valid   = '0;
        req_adr     = '0;
        req_d       = '0;
        clear_start = 1'b0;
        clear_color = '0;

        // Reset held with random inputs
        for (int k = 0; k < 3; k++) begin
            @(posedge CLOCK_50); #1;
            req_valid   = 3'($urandom);
            req_adr     = 48'({$urandom, $urandom});
            req_d       = 72'({$urandom, $urandom, $urandom});
            clear_start = 1'($urandom);
            clear_color = 24'($urandom);
            #1;
            chk("rst_we", 64'(vram_we), 64'd0);
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_busy", 64'(clear_busy), 64'd0);
        end
        @(posedge CLOCK_50); #1;
        req_valid   = '0;
        clear_start = 1'b0;
        reset_n     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLOCK_50); #1;
            chk("idle_we", 64'(vram_we), 64'd0);
        end

        // Single requester 1, four back-to-back writes
        for (int k = 0; k < 4; k++) begin
            @(posedge CLOCK_50); #1;
            req_valid         = 3'b010;
            req_adr[AW +: AW] = 16'h0010 + 16'(k);
            req_d[DW +: DW]   = 24'hFFFFFF;
            #1;
            chk("single_ready", 64'(req_ready), 64'b010);
            push(16'h0010 + 16'(k), 24'hFFFFFF, 3'd1);
        end
        @(posedge CLOCK_50); #1;
        req_valid = '0;
        repeat (3) @(posedge CLOCK_50);
        #1 chk("single_drain", 64'(exp_q.size()), 64'd0);

        // Contention from reset: 0,1,2,0,1,2
        reset_n = 1'b0;
        #3 reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLOCK_50); #1;
            req_valid = 3'b111;
            for (int i = 0; i < N_REQ; i++) begin
                req_adr[i*AW +: AW] = 16'(16'h0100 * (i + 1) + c);
                req_d[i*DW +: DW]   = 24'(24'hA00000 + 24'h010000 * i + c);
            end
            #1;
            chk("cont_ready", 64'(req_ready), 64'(3'b001 << exp_gid[c]));
            push(16'(16'h0100 * (exp_gid[c] + 1) + c),
                 24'(24'hA00000 + 24'h010000 * exp_gid[c] + c), exp_gid[c]);
        end
        @(posedge CLOCK_50); #1;
        req_valid = '0;
        repeat (3) @(posedge CLOCK_50);
        #1 chk("cont_drain", 64'(exp_q.size()), 64'd0);

        // Clear with req0 pending and a restart pulse at write 1000
        @(posedge CLOCK_50); #1;
        req_valid          = 3'b001;
        req_adr[0 +: AW]   = 16'h0ABC;
        req_d[0 +: DW]     = 24'h123456;
        clear_start        = 1'b1;
        clear_color        = 24'h0000FF;
        #1;
        chk("clr_start_ready", 64'(req_ready), 64'd0);
        for (int k = 0; k < FBW; k++) push(16'(k), 24'h0000FF, 3'd7);
        push(16'h0ABC, 24'h123456, 3'd0);
        @(posedge CLOCK_50); #1;
        clear_start = 1'b0;
        clear_color = 24'hFF0000;
        busy_cycles = 0;
        timed_out   = 1'b1;
        for (int c = 0; c < 60000; c++) begin
            #1;
            if (!clear_busy) begin
                timed_out = 1'b0;
                break;
            end
            chk("clr_ready", 64'(req_ready), 64'd0);
            clear_start = (busy_cycles == 1000);
            busy_cycles++;
            @(posedge CLOCK_50); #1;
        end
        clear_start = 1'b0;
        chk("clr_timeout", 64'(timed_out), 64'd0);
        chk("clr_busy_cycles", 64'(busy_cycles), 64'(FBW));
        chk("clr_last_adr", 64'(vram_wadr), 64'(FBW - 1));
        chk("clr_after_ready", 64'(req_ready), 64'b001);
        @(posedge CLOCK_50); #1;
        req_valid = '0;
        repeat (3) @(posedge CLOCK_50);
        #1 chk("clr_drain", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a clear
        @(posedge CLOCK_50); #1;
        clear_start = 1'b1;
        clear_color = 24'h00FF00;
        for (int k = 0; k < 500; k++) push(16'(k), 24'h00FF00, 3'd7);
        @(posedge CLOCK_50); #1;
        clear_start = 1'b0;
        repeat (501) @(posedge CLOCK_50);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_we", 64'(vram_we), 64'd0);
        chk("midrst_busy", 64'(clear_busy), 64'd0);
        @(negedge CLOCK_50); #1;
        chk("midrst_queue", 64'(exp_q.size()), 64'd0);
        @(posedge CLOCK_50); #1;
        reset_n            = 1'b1;
        req_valid          = 3'b100;
        req_adr[2*AW +: AW] = 16'h2222;
        req_d[2*DW +: DW]   = 24'h0F0F0F;
        #1;
        chk("postrst_ready", 64'(req_ready), 64'b100);
        push(16'h2222, 24'h0F0F0F, 3'd2);
        @(posedge CLOCK_50); #1;
        req_valid = '0;
        repeat (3) @(posedge CLOCK_50);
        #1 chk("final_drain", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
